// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles the fetch-side push port, the decode-side pop port and the
// occupancy/status outputs of the fetch queue.
//   slave  : the queue itself (drives o_*, samples i_*)
//   master : the environment (fetch + decode + hazard control)
// Signal names keep the i_/o_ direction prefixes as seen from the queue.
interface fetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                       i_flush;
    logic                       i_valid;
    logic [ADDR_WIDTH-1:0]      i_pc;
    logic [DATA_WIDTH-1:0]      i_instr;
    logic                       o_ready;
    logic                       o_valid;
    logic [ADDR_WIDTH-1:0]      o_pc;
    logic [DATA_WIDTH-1:0]      o_instr;
    logic                       o_misaligned;
    logic                       i_ready;
    logic                       o_full;
    logic                       o_empty;
    logic [$clog2(DEPTH):0]     o_count;

    modport slave (
        input  i_flush, i_valid, i_pc, i_instr, i_ready,
        output o_ready, o_valid, o_pc, o_instr, o_misaligned,
               o_full, o_empty, o_count
    );

    modport master (
        output i_flush, i_valid, i_pc, i_instr, i_ready,
        input  o_ready, o_valid, o_pc, o_instr, o_misaligned,
               o_full, o_empty, o_count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// In-order FIFO decoupling instruction fetch from decode. Holds {pc, instr}
// pairs, absorbs decode stalls, raises back-pressure when full and discards
// everything on a pc redirect.
// Ports:
//   clk    - clock
//   rst_n  - synchronous reset, active-low (control state only)
//   fq     - fetch_queue_if.slave:
//              i_flush        redirect, drop all entries
//              i_valid/i_pc/i_instr  push side from fetch
//              o_ready        push accepted when high (= !o_full)
//              o_valid/o_pc/o_instr/o_misaligned  head entry for decode
//              i_ready        decode consumes head
//              o_full/o_empty/o_count  occupancy status
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_queue_if.slave      fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Storage carries no reset; only pointers and count are control state.
    logic [ADDR_WIDTH-1:0] mem_pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // Both qualifiers come from registered state, so i_ready never
    // reaches o_ready combinationally; a full queue refuses a push even
    // when a pop happens in the same cycle.
    assign push  = fq.i_valid & ~full;
    assign pop   = fq.i_ready & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A push coinciding with a flush is dropped; the fetch unit refetches.
    always_ff @(posedge clk) begin
        if (push && !fq.i_flush) begin
            mem_pc_q[wr_ptr_q]    <= fq.i_pc;
            mem_instr_q[wr_ptr_q] <= fq.i_instr;
        end
    end

    assign fq.o_ready      = ~full;
    assign fq.o_full       = full;
    assign fq.o_empty      = empty;
    assign fq.o_count      = count_q;
    assign fq.o_valid      = ~empty;
    // Head is read without a register; gated so stale storage never leaks.
    assign fq.o_pc         = empty ? '0 : mem_pc_q[rd_ptr_q];
    assign fq.o_instr      = empty ? '0 : mem_instr_q[rd_ptr_q];
    assign fq.o_misaligned = ~empty & (mem_pc_q[rd_ptr_q][1:0] != 2'b00);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= CNT_FULL)
                else $error("fetch_queue occupancy above DEPTH: %0d", count_q);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (fq.slave)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    entry_t model_q[$];
    bit     model_ok = 0;
    int     n_pass = 0;
    int     n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: a bounded in-order queue, cleared by reset or redirect.
    always @(posedge clk) begin
        if (!rst_n || fq.i_flush) begin
            model_q.delete();
            model_ok = (!rst_n) ? 1'b1 : model_ok;
        end else begin
            bit can_push, can_pop;
            can_push = fq.i_valid && (model_q.size() < DEPTH);
            can_pop  = fq.i_ready && (model_q.size() > 0);
            if (can_pop)  void'(model_q.pop_front());
            if (can_push) model_q.push_back('{pc: fq.i_pc, instr: fq.i_instr});
        end
    end

    // Every cycle after the first reset, outputs must match the model.
    always @(negedge clk) begin
        if (model_ok) begin
            int            n;
            logic [AW-1:0] epc;
            logic [DW-1:0] eins;
            n    = model_q.size();
            epc  = (n > 0) ? model_q[0].pc    : '0;
            eins = (n > 0) ? model_q[0].instr : '0;
            check("m_count", 64'(fq.o_count),   64'(n));
            check("m_valid", 64'(fq.o_valid),   64'(n > 0));
            check("m_empty", 64'(fq.o_empty),   64'(n == 0));
            check("m_full",  64'(fq.o_full),    64'(n == DEPTH));
            check("m_ready", 64'(fq.o_ready),   64'(n != DEPTH));
            check("m_pc",    64'(fq.o_pc),      64'(epc));
            check("m_instr", 64'(fq.o_instr),   64'(eins));
            check("m_mis",   64'(fq.o_misaligned), 64'((n > 0) && (epc[1:0] != 2'b00)));
        end
    end

    // One clock: apply inputs, take the edge, let outputs settle.
    task automatic cyc(input logic fl, input logic v, input logic [AW-1:0] pc,
                       input logic [DW-1:0] ins, input logic rdy);
        fq.i_flush = fl;
        fq.i_valid = v;
        fq.i_pc    = pc;
        fq.i_instr = ins;
        fq.i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, '0, '0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fq.i_flush = 0; fq.i_valid = 0; fq.i_pc = '0; fq.i_instr = '0; fq.i_ready = 0;
        #1;
        do_reset();
        check("rst_valid", 64'(fq.o_valid), 0);
        check("rst_empty", 64'(fq.o_empty), 1);
        check("rst_full",  64'(fq.o_full),  0);
        check("rst_ready", 64'(fq.o_ready), 1);
        check("rst_count", 64'(fq.o_count), 0);
        check("rst_pc",    64'(fq.o_pc),    0);

        // Three pushes, decode stalled
        for (int i = 0; i < 3; i++) cyc(0, 1, AW'(4 * i), DW'(32'h2001_0001 + i), 0);
        check("t1_count", 64'(fq.o_count), 3);
        check("t1_valid", 64'(fq.o_valid), 1);
        check("t1_pc",    64'(fq.o_pc),    0);
        check("t1_instr", 64'(fq.o_instr), 64'h2001_0001);

        // Fill to DEPTH, fifth push refused
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, AW'(32'h10 + 4 * i), DW'(32'hA0 + i), 0);
        check("t2_full",  64'(fq.o_full),  1);
        check("t2_ready", 64'(fq.o_ready), 0);
        cyc(0, 1, AW'(32'h20), DW'(32'hA4), 0);
        check("t2_count5", 64'(fq.o_count), 4);
        cyc(0, 0, '0, '0, 1);
        check("t2_ready_after_pop", 64'(fq.o_ready), 1);
        check("t2_count_after_pop", 64'(fq.o_count), 3);
        check("t2_head_after_pop",  64'(fq.o_pc),    64'h14);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 1);
        check("t2_drained", 64'(fq.o_empty), 1);

        // Steady stream: one in, one out every cycle
        cyc(0, 1, AW'(32'h100), DW'(32'h100), 1);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 1, AW'(32'h100 + 4 * k), DW'(32'h100 + k), 1);
            check("t3_count", 64'(fq.o_count), 1);
            check("t3_pc",    64'(fq.o_pc),    64'(32'h100 + 4 * k));
        end
        cyc(0, 0, '0, '0, 1);
        check("t3_empty", 64'(fq.o_empty), 1);

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(0, 1, AW'(32'h200 + 4 * i), DW'(32'hB0 + i), 0);
        cyc(1, 1, AW'(32'h300), DW'(32'hC0), 1);
        check("t4_count", 64'(fq.o_count), 0);
        check("t4_valid", 64'(fq.o_valid), 0);
        cyc(0, 0, '0, '0, 0);
        check("t4_push_absent", 64'(fq.o_valid), 0);
        cyc(1, 0, '0, '0, 1);
        check("t4_flush_empty", 64'(fq.o_empty), 1);

        // Misaligned tag passes through
        cyc(0, 1, AW'(32'h102), DW'(32'hD0), 0);
        check("t5_valid", 64'(fq.o_valid), 1);
        check("t5_mis",   64'(fq.o_misaligned), 1);
        cyc(0, 1, AW'(32'h104), DW'(32'hD1), 1);
        check("t5_mis_clear", 64'(fq.o_misaligned), 0);
        check("t5_pc",        64'(fq.o_pc), 64'h104);
        cyc(0, 0, '0, '0, 1);

        // Mid-operation reset
        for (int i = 0; i < 2; i++) cyc(0, 1, AW'(32'h400 + 4 * i), DW'(32'hE0 + i), 0);
        do_reset();
        check("t6_valid", 64'(fq.o_valid), 0);
        check("t6_empty", 64'(fq.o_empty), 1);
        check("t6_count", 64'(fq.o_count), 0);
        check("t6_pc",    64'(fq.o_pc),    0);
        cyc(0, 0, '0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
